// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha state engine: word type,
// quarter-round word selection per step, and rotate amounts.
package chacha_pkg;

    typedef logic [31:0] word_t;

    localparam int NUM_WORDS    = 16;
    localparam int STEPS_PER_DR = 8;

    localparam int ROT_1 = 16;
    localparam int ROT_2 = 12;
    localparam int ROT_3 = 8;
    localparam int ROT_4 = 7;

    // One entry per step; nibbles are the a/b/c/d word indices, a in the top nibble.
    // Steps 0-3 are the column round, steps 4-7 the diagonal round.
    localparam logic [STEPS_PER_DR-1:0][15:0] QR_IDX = {
        16'h3_4_9_E,
        16'h2_7_8_D,
        16'h1_6_B_C,
        16'h0_5_A_F,
        16'h3_7_B_F,
        16'h2_6_A_E,
        16'h1_5_9_D,
        16'h0_4_8_C
    };

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } fsm_t;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_quarter_round
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_new,
    output word_t b_new,
    output word_t c_new,
    output word_t d_new
);

    word_t a1, b1, c1, d1;
    word_t a2, b2, c2, d2;

    always_comb begin
        a1 = a + b;
        d1 = rotl(d ^ a1, ROT_1);
        c1 = c + d1;
        b1 = rotl(b ^ c1, ROT_2);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, ROT_3);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, ROT_4);
    end

    assign a_new = a2;
    assign b_new = b2;
    assign c_new = c2;
    assign d_new = d2;

endmodule

// File: rtl/chacha_state_core.sv
// ChaCha state engine: 16-word register file with word write/read and a
// sequencer that applies one quarter-round per clock for DOUBLE_ROUNDS double rounds.
//
// state   | meaning
// ST_IDLE | accepts writes and start requests, busy=0
// ST_RUN  | one quarter-round per edge, strobes ignored, busy=1
module chacha_state_core
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic [3:0]  addr,
    input  logic        write_n,
    input  logic        round_n,
    output logic [31:0] data_out,
    output logic        busy
);

    localparam int DR_W = (DOUBLE_ROUNDS > 1) ? $clog2(DOUBLE_ROUNDS) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DOUBLE_ROUNDS - 1);

    fsm_t            fsm;
    word_t           state_q [NUM_WORDS];
    logic [2:0]      step;
    logic [DR_W-1:0] dr;

    logic [15:0] sel;
    logic [3:0]  ix_a, ix_b, ix_c, ix_d;
    word_t       qa, qb, qc, qd;

    assign sel  = QR_IDX[step];
    assign ix_a = sel[15:12];
    assign ix_b = sel[11:8];
    assign ix_c = sel[7:4];
    assign ix_d = sel[3:0];

    chacha_quarter_round u_qr (
        .a     (state_q[ix_a]),
        .b     (state_q[ix_b]),
        .c     (state_q[ix_c]),
        .d     (state_q[ix_d]),
        .a_new (qa),
        .b_new (qb),
        .c_new (qc),
        .d_new (qd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                state_q[i] <= '0;
            end
            fsm      <= ST_IDLE;
            data_out <= '0;
            busy     <= 1'b0;
            step     <= '0;
            dr       <= '0;
        end else begin
            // Read port tracks the register file every edge, intermediate values included.
            data_out <= state_q[addr];
            case (fsm)
                ST_IDLE: begin
                    if (!write_n) begin
                        state_q[addr] <= data_in;
                    end
                    if (!round_n) begin
                        fsm  <= ST_RUN;
                        busy <= 1'b1;
                        step <= '0;
                        dr   <= '0;
                    end
                end
                ST_RUN: begin
                    state_q[ix_a] <= qa;
                    state_q[ix_b] <= qb;
                    state_q[ix_c] <= qc;
                    state_q[ix_d] <= qd;
                    step <= step + 3'd1;
                    if (step == 3'(STEPS_PER_DR - 1)) begin
                        if (dr == DR_LAST) begin
                            fsm  <= ST_IDLE;
                            busy <= 1'b0;
                            dr   <= '0;
                        end else begin
                            dr <= dr + 1'b1;
                        end
                    end
                end
                default: begin
                    fsm  <= ST_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
